// File: rtl/div_seq_ctrl.sv
// Sequential signed divider: one non-restoring step per clock, sign fix-up at the end, start/busy/done handshake.
// Define DIV_ZERO_DETECT_EN to add the ZERO state that short-circuits a zero divisor and raises div_by_zero.
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FINISH
`ifdef DIV_ZERO_DETECT_EN
        , ZERO
`endif
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   m;
    logic             sign_dd;
    logic             sign_dv;

    logic [WIDTH-1:0] dd_abs;
    logic [WIDTH-1:0] dv_abs;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   a_step;
    logic [WIDTH:0]   a_fix;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dd_signed;

    // Magnitudes fit in WIDTH unsigned bits, so the most negative operand maps to 2^(WIDTH-1).
    assign dd_abs = dividend[WIDTH-1] ? -dividend : dividend;
    assign dv_abs = divisor[WIDTH-1]  ? -divisor  : divisor;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_DETECT_EN
                    state_next = (divisor == '0) ? ZERO : ITER;
`else
                    state_next = ITER;
`endif
                end
            end
            ITER:    if (count == LAST) state_next = FINISH;
            FINISH:  state_next = IDLE;
`ifdef DIV_ZERO_DETECT_EN
            ZERO:    state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // The sign of the pre-shift remainder picks add or subtract; intermediate wrap is harmless mod 2^(WIDTH+1).
    always_comb begin
        a_shift   = {a[WIDTH-1:0], q[WIDTH-1]};
        a_step    = a[WIDTH] ? (a_shift + m) : (a_shift - m);
        a_fix     = a[WIDTH] ? (a + m) : a;
        quo       = (sign_dd ^ sign_dv) ? -q : q;
        rem       = sign_dd ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
        dd_signed = sign_dd ? -q : q;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count   <= '0;
            a       <= '0;
            q       <= '0;
            m       <= '0;
            sign_dd <= 1'b0;
            sign_dv <= 1'b0;
            out     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_dd <= dividend[WIDTH-1];
                        sign_dv <= divisor[WIDTH-1];
                        q       <= dd_abs;
                        m       <= {1'b0, dv_abs};
                        a       <= '0;
                        count   <= '0;
                    end
                end
                ITER: begin
                    a     <= a_step;
                    q     <= {q[WIDTH-2:0], ~a_step[WIDTH]};
                    count <= count + CW'(1);
                end
                FINISH: begin
                    out   <= {rem, quo};
                    done  <= 1'b1;
                    count <= '0;
                end
`ifdef DIV_ZERO_DETECT_EN
                ZERO: begin
                    out  <= {dd_signed, {WIDTH{1'b1}}};
                    done <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)                  div_by_zero <= 1'b0;
        else if (state == FINISH)  div_by_zero <= 1'b0;
        else if (state == ZERO)    div_by_zero <= 1'b1;
    end
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: vector table plus hand-written sequences, scoreboard queue of expected results.
module tb_div_seq_ctrl;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] out;

    int total = 0;
    int bad   = 0;

    logic [64:0] sb_q[$];

    typedef struct {
        logic [31:0] dd;
        logic [31:0] dv;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[12];

    div_seq_ctrl #(.WIDTH(32)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .out         (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] dd, input logic [31:0] dv);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Called one step after the start edge; follows the op to its done pulse and compares with the scoreboard.
    task automatic waitDone(input int exp_lat, input int repulse_at);
        int lat = 0;
        int busy_cnt = 0;
        logic [64:0] exp;
        checkOutput("done_low_after_start", {63'd0, done}, 64'd0);
        while (!done && lat < 200) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
            if (repulse_at > 0 && lat == repulse_at - 1) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end
            if (repulse_at > 0 && lat == repulse_at) start = 1'b0;
        end
        if (!done) begin
            bad++;
            total++;
            $display("[TB] FAIL timeout: no done after %0d cycles, expected at %0d", lat, exp_lat);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        exp = sb_q.pop_front();
        checkOutput("latency", 64'(lat), 64'(exp_lat));
        checkOutput("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
        checkOutput("busy_at_done", {63'd0, busy}, 64'd0);
        checkOutput("out", out, exp[63:0]);
        checkOutput("div_by_zero", {63'd0, div_by_zero}, {63'd0, exp[64]});
    endtask

    task automatic runOp(input logic [31:0] dd, input logic [31:0] dv, input logic [63:0] exp_out,
                         input logic exp_dbz, input int exp_lat);
        sb_q.push_back({exp_dbz, exp_out});
        applyStimulus(dd, dv);
        waitDone(exp_lat, 0);
    endtask

    initial begin
        int quiet;
        vecs[0]  = '{32'd7,          32'd2,          {32'd1,          32'd3}};
        vecs[1]  = '{-32'sd7,        32'd2,          {32'hFFFFFFFF,   32'hFFFFFFFD}};
        vecs[2]  = '{32'd7,          -32'sd2,        {32'd1,          32'hFFFFFFFD}};
        vecs[3]  = '{-32'sd7,        -32'sd2,        {32'hFFFFFFFF,   32'd3}};
        vecs[4]  = '{32'h80000000,   32'hFFFFFFFF,   {32'd0,          32'h80000000}};
        vecs[5]  = '{32'h7FFFFFFF,   32'd1,          {32'd0,          32'h7FFFFFFF}};
        vecs[6]  = '{32'd5,          32'd9,          {32'd5,          32'd0}};
        vecs[7]  = '{32'd100,        32'd7,          {32'd2,          32'd14}};
        vecs[8]  = '{-32'sd100,      32'd7,          {32'hFFFFFFFE,   32'hFFFFFFF2}};
        vecs[9]  = '{32'h80000000,   32'd2,          {32'd0,          32'hC0000000}};
        vecs[10] = '{32'h80000000,   32'h7FFFFFFF,   {32'hFFFFFFFF,   32'hFFFFFFFF}};
        vecs[11] = '{32'd0,          32'd5,          {32'd0,          32'd0}};

        clr      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        @(posedge clk);
        #1;
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_dbz",  {63'd0, div_by_zero}, 64'd0);
        checkOutput("reset_out",  out, 64'd0);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back: each op starts in the cycle the previous done is high.
        for (int i = 0; i < 12; i++) begin
            runOp(vecs[i].dd, vecs[i].dv, vecs[i].exp, 1'b0, 33);
        end

`ifdef DIV_ZERO_DETECT_EN
        runOp(32'd100, 32'd0, {32'd100, 32'hFFFFFFFF}, 1'b1, 1);
        runOp(-32'sd5, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1'b1, 1);
        runOp(32'd9,   32'd3, {32'd0, 32'd3}, 1'b0, 33);
`endif

        // A second start mid-operation must not disturb the running one or queue another.
        sb_q.push_back({1'b0, 32'd1, 32'd3});
        applyStimulus(32'd7, 32'd2);
        waitDone(33, 5);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ignored_start_no_op", {63'd0, busy}, 64'd0);

        // Asynchronous reset in the middle of an operation.
        applyStimulus(32'd50, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        checkOutput("midreset_busy", {63'd0, busy}, 64'd0);
        checkOutput("midreset_done", {63'd0, done}, 64'd0);
        checkOutput("midreset_dbz",  {63'd0, div_by_zero}, 64'd0);
        checkOutput("midreset_out",  out, 64'd0);
        @(negedge clk);
        clr = 1'b1;
        quiet = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) quiet++;
        end
        checkOutput("midreset_no_done", 64'(quiet), 64'd0);
        runOp(32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 33);

        checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Multi-cycle sequencer for signed 32-bit division feeding the CPU's 64-bit Z register (remainder high, quotient low). It runs one non-restoring step per clock on registered magnitude operands and applies sign correction at the end. A start/busy/done handshake lets the control unit stall the datapath. This replaces single-cycle combinational division on the critical path.

## Interface

- `WIDTH`, default 32: operand width. The iteration count equals `WIDTH`, and `out` is 2*`WIDTH` bits wide.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clr`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  WIDTH  signed dividend; sampled on the start edge.
- `divisor`  in  WIDTH  signed divisor; sampled on the start edge.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  single-cycle completion pulse.
- `div_by_zero`  out  1  status bit for the last completed operation (see Configuration).
- `out`  out  2*WIDTH  {remainder, quotient}; holds its value until the next completion.

## Operation

- States are IDLE, ITER and FINISH, plus ZERO when the macro is enabled.
- **IDLE**
  - On `start`=1, register the sign bits of both operands.
  - Register the magnitudes of both operands as (WIDTH+1)-bit unsigned values, so that -2^31 has magnitude 0x80000000.
  - Clear the partial remainder A (WIDTH+1 bits), set count=0, and go to ITER.
- **ITER** (one step per cycle)
  - Shift {A,Q} left by 1.
  - If A is negative, A = A + |divisor|; otherwise A = A - |divisor|.
  - Set Q[0] = ~A[msb].
  - Increment count. When count reaches WIDTH-1, go to FINISH.
- **FINISH**
  - If A is negative, add |divisor| to A (remainder restore).
  - Quotient sign = sign(dividend) XOR sign(divisor). Negate Q if that sign is set.
  - Remainder sign = sign(dividend). Negate A if the dividend was negative.
  - Load `out` = {A[WIDTH-1:0], Q}, pulse `done`, clear `div_by_zero`, and return to IDLE.
- Division truncates toward zero, so quotient*divisor + remainder = dividend holds whenever the quotient is representable.
- Overflow case: -2^31 / -1 gives quotient 0x80000000 and remainder 0. No flag is raised.
- `start` while `busy` is ignored. The in-flight operation is unaffected.
- `dividend` and `divisor` may change freely after the start edge.

## Timing

- Reset (`clr`=0, asynchronous) forces:
  - state=IDLE and count=0
  - `busy`=0, `done`=0, `div_by_zero`=0
  - `out`=0
- Reset mid-operation aborts the operation. No `done` is produced, and the next `start` after release begins cleanly.
- Let the start edge be E. Then:
  - `busy` rises after E.
  - The WIDTH iteration edges are E+1 through E+WIDTH.
  - FINISH is edge E+WIDTH+1 (E+33 for WIDTH=32).
- At edge E+33:
  - `out` updates.
  - `done` goes high for exactly one cycle.
  - `busy` falls.
- Back-to-back operation: `start` may be asserted in the cycle `done` is high. It is sampled on the next edge, so the throughput is one operation per 34 cycles.
- `done` and `busy` are never high in the same cycle.

## Configuration

- Macro: `DIV_ZERO_DETECT_EN`.
- **Defined**
  - In IDLE with `start`=1 and `divisor`==0, go to ZERO instead of ITER.
  - On the next edge (E+1), set `out`={dividend, 32'hFFFFFFFF} and `div_by_zero`=1, pulse `done`, and drop `busy`.
  - `div_by_zero` holds until the next completion.
- **Undefined**
  - No ZERO state; `div_by_zero` is tied to 0.
  - A zero divisor runs the full 33-cycle sequence. The resulting `out` value is unspecified and must not be checked.

## Test plan

- 7 / 2 -> `done` at E+33; `out`={32'd1, 32'd3}; `busy` high for exactly 33 cycles.
- -7 / 2 -> `out`={32'hFFFFFFFF, 32'hFFFFFFFD}. Also check 7 / -2 -> {32'd1, 32'hFFFFFFFD}, and -7 / -2 -> {32'hFFFFFFFF, 32'd3}.
- -2^31 / -1 -> `out`={32'd0, 32'h80000000}. Also check 0x7FFFFFFF / 1 -> {0, 32'h7FFFFFFF}, and 5 / 9 -> {32'd5, 32'd0}.
- Divisor 0 with `DIV_ZERO_DETECT_EN` and dividend 100 -> `done` at E+1; `out`={32'd100, 32'hFFFFFFFF}; `div_by_zero`=1. A following 9 / 3 clears `div_by_zero` and gives {0, 3}.
- `start` re-pulsed with new operands at E+5 -> ignored; the first result is returned unchanged.
- `clr` pulsed low at E+10 -> all outputs 0 immediately and no `done`. A new 100 / 7 then returns {32'd2, 32'd14} at its own E+33.
